// File: rtl/imm_encoder.sv
// Immediate encoder: scatters a signed immediate into the I/S/B/J field positions of a base
// instruction and flags unrepresentable values, through a 2-stage elastic valid/ready pipeline.
module imm_encoder #(
   parameter int CNT_W    = 8,
   parameter bit CHECK_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_immsrc,
   input  logic [31:0]      in_imm,
   input  logic [31:0]      in_base,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic [1:0]       out_err_code,
   output logic [CNT_W-1:0] err_cnt,
   input  logic             cnt_clr
);

   localparam logic [1:0] FMT_I = 2'b00;
   localparam logic [1:0] FMT_S = 2'b01;
   localparam logic [1:0] FMT_B = 2'b10;
   localparam logic [1:0] FMT_J = 2'b11;

   logic [31:0]      pack_instr;
   logic             range_err;
   logic             misalign;
   logic [1:0]       pack_code;

   logic             s1_valid_q, s1_valid_d;
   logic [31:0]      s1_instr_q, s1_instr_d;
   logic [1:0]       s1_code_q, s1_code_d;
   logic             out_valid_q, out_valid_d;
   logic [31:0]      out_instr_q, out_instr_d;
   logic [1:0]       out_code_q, out_code_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             s2_load;
   logic             s1_load;
   logic             out_fire;

   // Range is judged on the bits discarded by packing: they must all equal the kept sign bit.
   always_comb begin
      pack_instr = in_base;
      range_err  = 1'b0;
      misalign   = 1'b0;
      case (in_immsrc)
         FMT_I: begin
            pack_instr[31:20] = in_imm[11:0];
            range_err = ~((&in_imm[31:11]) | ~(|in_imm[31:11]));
         end
         FMT_S: begin
            pack_instr[31:25] = in_imm[11:5];
            pack_instr[11:7]  = in_imm[4:0];
            range_err = ~((&in_imm[31:11]) | ~(|in_imm[31:11]));
         end
         FMT_B: begin
            pack_instr[31]    = in_imm[12];
            pack_instr[30:25] = in_imm[10:5];
            pack_instr[11:8]  = in_imm[4:1];
            pack_instr[7]     = in_imm[11];
            range_err = ~((&in_imm[31:12]) | ~(|in_imm[31:12]));
            misalign  = in_imm[0];
         end
         FMT_J: begin
            pack_instr[31]    = in_imm[20];
            pack_instr[30:21] = in_imm[10:1];
            pack_instr[20]    = in_imm[11];
            pack_instr[19:12] = in_imm[19:12];
            range_err = ~((&in_imm[31:20]) | ~(|in_imm[31:20]));
            misalign  = in_imm[0];
         end
         default: pack_instr = in_base;
      endcase
      pack_code = CHECK_EN ? {misalign, range_err} : 2'b00;
   end

   assign s2_load  = ~out_valid_q | out_ready;
   assign s1_load  = ~s1_valid_q | s2_load;
   assign out_fire = out_valid_q & out_ready;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_instr_d  = s1_instr_q;
      s1_code_d   = s1_code_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_code_d  = out_code_q;
      if (s2_load) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_instr_d = s1_instr_q;
            out_code_d  = s1_code_q;
         end
      end
      if (s1_load) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_instr_d = pack_instr;
            s1_code_d  = pack_code;
         end
      end
   end

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (out_fire && (|out_code_q) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_instr_q  <= '0;
         s1_code_q   <= '0;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_code_q  <= '0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_instr_q  <= s1_instr_d;
         s1_code_q   <= s1_code_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_code_q  <= out_code_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready     = s1_load;
   assign out_valid    = out_valid_q;
   assign out_instr    = out_instr_q;
   assign out_err_code = out_code_q;
   assign out_err      = |out_code_q;
   assign err_cnt      = cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: a driver pushes expected words, a negedge monitor pops and
// compares; a second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [1:0]  in_immsrc = 2'b00;
   logic [31:0] in_imm = '0;
   logic [31:0] in_base = '0;
   logic        out_ready = 1'b1;
   logic        cnt_clr = 1'b0;

   logic        in_ready, out_valid, out_err;
   logic [31:0] out_instr;
   logic [1:0]  out_err_code;
   logic [7:0]  err_cnt;

   logic        s_in_ready, s_out_valid, s_out_err;
   logic [31:0] s_out_instr;
   logic [1:0]  s_out_err_code;
   logic [1:0]  s_err_cnt;

   imm_encoder #(.CNT_W(8), .CHECK_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_immsrc(in_immsrc), .in_imm(in_imm), .in_base(in_base),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_err(out_err), .out_err_code(out_err_code), .err_cnt(err_cnt), .cnt_clr(cnt_clr)
   );

   imm_encoder #(.CNT_W(2), .CHECK_EN(1'b1)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_immsrc(in_immsrc), .in_imm(in_imm), .in_base(in_base),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
      .out_err(s_out_err), .out_err_code(s_out_err_code), .err_cnt(s_err_cnt), .cnt_clr(cnt_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [1:0]  code;
      logic [1:0]  src;
      logic [31:0] imm;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   model_cnt = 0;
   int   stall_cnt = 0;
   bit   rand_bp = 1'b0;
   bit   rand_clr = 1'b0;
   bit   started = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Which immediate bit lands at instruction bit k, or -1 when the base bit is kept.
   function automatic int src_bit(input logic [1:0] fmt, input int k);
      case (fmt)
         2'd0: return (k >= 20) ? k - 20 : -1;
         2'd1: return (k >= 25) ? k - 20 : ((k >= 7 && k <= 11) ? k - 7 : -1);
         2'd2: begin
            if (k == 31) return 12;
            if (k >= 25 && k <= 30) return k - 20;
            if (k >= 8 && k <= 11) return k - 7;
            if (k == 7) return 11;
            return -1;
         end
         default: begin
            if (k == 31) return 20;
            if (k >= 21 && k <= 30) return k - 20;
            if (k == 20) return 11;
            if (k >= 12 && k <= 19) return k;
            return -1;
         end
      endcase
   endfunction

   function automatic exp_t model(input logic [1:0] src, input logic [31:0] imm,
                                  input logic [31:0] base);
      exp_t e;
      int v, lo, hi, s;
      v = $signed(imm);
      case (src)
         2'd2:    begin lo = -4096;    hi = 4095;    end
         2'd3:    begin lo = -1048576; hi = 1048575; end
         default: begin lo = -2048;    hi = 2047;    end
      endcase
      e.instr = base;
      for (int k = 0; k < 32; k++) begin
         s = src_bit(src, k);
         if (s >= 0) e.instr[k] = imm[s];
      end
      e.code[0] = (v < lo) || (v > hi);
      e.code[1] = src[1] && imm[0];
      e.src = src;
      e.imm = imm;
      e.acc = 0;
      return e;
   endfunction

   // The immediate extender this block inverts.
   function automatic logic [31:0] extend(input logic [31:0] i, input logic [1:0] src);
      case (src)
         2'd0:    return {{20{i[31]}}, i[31:20]};
         2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
         2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      endcase
   endfunction

   task automatic send(input exp_t e, input logic [31:0] base);
      int n;
      n = 0;
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_immsrc = e.src;
      in_imm    = e.imm;
      in_base   = base;
      #2;
      while (!in_ready) begin
         @(posedge clk); #3;
         n++;
         if (n > 200) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
         end
      end
      e.acc = cyc + 1;
      q.push_back(e);
   endtask

   task automatic send_m(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base);
      send(model(src, imm, base), base);
   endtask

   task automatic send_x(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base,
                         input logic [31:0] xi, input logic [1:0] xc);
      exp_t e;
      e = model(src, imm, base);
      e.instr = xi;
      e.code  = xc;
      send(e, base);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic mid_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      chk("rst_err_cnt_small", {30'd0, s_err_cnt}, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      q.delete();
      model_cnt = 0;
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
   endtask

   initial forever begin
      @(posedge clk); #2;
      if (stall_cnt > 0) begin
         out_ready = 1'b0;
         stall_cnt--;
      end else if (rand_bp) begin
         out_ready = ($urandom_range(0, 3) != 0);
      end else begin
         out_ready = 1'b1;
      end
      cnt_clr = rand_clr && ($urandom_range(0, 31) == 0);
   end

   int   occ;
   bit   ev;
   bit   hs_err;
   int   sat;

   always @(negedge clk) begin
      if (rst_n && started) begin
         hs_err = 1'b0;
         occ = q.size();
         if (occ > 0 && q[$].acc > cyc) occ--;
         ev = (q.size() > 0) && (cyc >= q[0].acc + 1);
         chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
         chk("in_ready", {31'd0, in_ready}, {31'd0, (occ < 2) || out_ready});
         if (out_valid && ev) begin
            chk("out_instr", out_instr, q[0].instr);
            chk("out_err_code", {30'd0, out_err_code}, {30'd0, q[0].code});
            chk("out_err", {31'd0, out_err}, {31'd0, q[0].code != 2'b00});
            chk("small_instr", s_out_instr, q[0].instr);
            if (q[0].code == 2'b00)
               chk("round_trip", extend(out_instr, q[0].src), q[0].imm);
            if (out_ready) begin
               hs_err = (q[0].code != 2'b00);
               void'(q.pop_front());
            end
         end
         sat = (model_cnt > 255) ? 255 : model_cnt;
         chk("err_cnt", {24'd0, err_cnt}, sat);
         sat = (model_cnt > 3) ? 3 : model_cnt;
         chk("err_cnt_sat2", {30'd0, s_err_cnt}, sat);
         if (cnt_clr) model_cnt = 0;
         else if (hs_err) model_cnt++;
      end
   end

   initial begin
      int src, v, n;
      #12;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_out_instr", out_instr, 32'd0);
      chk("reset_out_err", {29'd0, out_err, out_err_code}, 32'd0);
      chk("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      started = 1'b1;

      send_x(2'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 2'b00);
      idle(4);
      send_x(2'd2, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 2'b00);
      send_m(2'd2, 32'd4096, 32'h0000_0063);
      send_m(2'd2, 32'd3, 32'h0000_0063);
      send_x(2'd3, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 2'b00);
      send_m(2'd3, 32'h0010_0000, 32'h0000_006F);
      send_m(2'd0, 32'd2047, 32'h1234_5093);
      send_m(2'd0, 32'hFFFF_F800, 32'h1234_5093);
      send_m(2'd1, 32'd2048, 32'hABCD_E123);
      send_m(2'd1, 32'hFFFF_F7FF, 32'hABCD_E123);
      send_m(2'd2, 32'hFFFF_F000, 32'hFFFF_FFFF);
      send_m(2'd2, 32'hFFFF_EFFE, 32'hFFFF_FFFF);
      send_m(2'd3, 32'hFFF0_0000, 32'h0000_0000);
      send_m(2'd3, 32'h000F_FFFF, 32'h0000_0000);
      idle(4);

      for (int i = 0; i < 8; i++) begin
         if (i == 4) stall_cnt = 3;
         send_m(2'(i % 4), $urandom(), $urandom());
      end
      idle(6);

      rand_bp = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         src = $urandom_range(0, 3);
         case (src)
            0, 1: v = $urandom_range(0, 4095) - 2048;
            2:    v = $urandom_range(0, 4095) * 2 - 4096;
            default: v = $urandom_range(0, 1048575) * 2 - 1048576;
         endcase
         send_m(2'(src), v, $urandom());
         if ($urandom_range(0, 7) == 0) idle(1);
      end

      rand_clr = 1'b1;
      for (int i = 0; i < 400; i++) begin
         send_m(2'($urandom_range(0, 3)), $urandom() >> $urandom_range(0, 31), $urandom());
      end
      rand_clr = 1'b0;
      idle(8);

      rand_bp = 1'b0;
      mid_reset();
      for (int i = 0; i < 5; i++) send_m(2'd0, 32'd5000, 32'h0000_0013);
      idle(6);
      send_m(2'd1, 32'hFFFF_0000, 32'h0000_0023);
      send_m(2'd2, 32'd7, 32'h0000_0063);
      n = 0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2;
      while (!(out_valid && out_err) && n < 50) begin
         @(posedge clk); #3;
         n++;
      end
      chk("clr_setup_seen", {31'd0, out_valid && out_err}, 32'd1);
      cnt_clr = 1'b1;
      idle(4);

      rand_bp = 1'b1;
      for (int i = 0; i < 6; i++) send_m(2'd3, $urandom(), $urandom());
      mid_reset();
      send_m(2'd0, 32'd100, 32'h0000_0013);
      send_m(2'd2, 32'd9000, 32'h0000_0063);

      rand_bp = 1'b0;
      idle(1);
      n = 0;
      while (q.size() > 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("drain", q.size(), 32'd0);
      @(posedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
